uart_tx_arbiter: RTL and testbench

Round-robin, frame-level arbiter that shares one UART byte transmitter among `N_REQ` independent byte-stream requesters. Each requester presents bytes with a `last` marker. Once granted, a requester keeps the transmitter until its last byte is accepted, so frames never interleave on the serial line. The block sits between the producers (FFT result formatters, status reporters) and `uart_tx_writer`, driving its `valid`/`data` inputs and consuming its `ready`.

---
 rtl/uart_tx_arb_pkg.sv | 35 +++
 rtl/rr_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and the round-robin search helper for the UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int MAX_W   = 5;
  localparam int MAX_REQ = 1 << MAX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit of valid_vec searching upward from ptr+1, wrapping at n.
  // Returns ptr when nothing is pending; callers qualify with an any-valid flag.
  function automatic int rr_next(input int ptr,
                                 input logic [MAX_REQ-1:0] valid_vec,
                                 input int n);
    int   win;
    int   idx;
    logic found;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && valid_vec[idx[MAX_W-1:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate from rr_ptr+1 and priority-encode.
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [$clog2(N_REQ)-1:0] win_id,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  logic [MAX_REQ-1:0] valid_vec;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_vec              = '0;
    valid_vec[N_REQ-1:0]   = req_valid;
    win_id                 = IW'(rr_next(int'(rr_ptr), valid_vec, N_REQ));
  end

  assign any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UART byte transmitter among N_REQ streams.
// Optional mid-frame stall timeout is built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0][7:0]    req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic                     down_valid,
  input  logic                     down_ready,
  output logic [7:0]               down_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_id;
  logic          any_valid;
  logic          slot_free;
  logic          accept;
  logic          revoke;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .rr_ptr    (rr_ptr),
    .req_valid (req_valid),
    .win_id    (win_id),
    .any       (any_valid)
  );

  // The output register can take a byte when empty or draining this cycle.
  assign slot_free = !down_valid || down_ready;
  assign accept    = (state == GRANT) && slot_free && req_valid[grant_id];
  assign busy      = (state == GRANT) || down_valid;

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = slot_free;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt;

  assign revoke = (state == GRANT) && !accept && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside GRANT, so every new grant starts counting from zero.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= revoke;
      if (state != GRANT || accept) idle_cnt <= '0;
      else if (!revoke)             idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign revoke             = 1'b0;
  assign timeout            = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      grant_id   <= '0;
      rr_ptr     <= IW'(N_REQ - 1);
      down_valid <= 1'b0;
      down_data  <= '0;
    end else begin
      if (accept) begin
        down_valid <= 1'b1;
        down_data  <= req_data[grant_id];
      end else if (down_ready) begin
        down_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= win_id;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A finished or revoked grantee drops to lowest priority.
          if ((accept && req_last[grant_id]) || revoke) begin
            rr_ptr <= grant_id;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources, expected serial stream queue.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 64;

  logic              clk;
  logic              arstn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][7:0] req_data;
  logic [N-1:0]      req_last;
  logic              down_valid;
  logic              down_ready;
  logic [7:0]        down_data;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout;

  int checks;
  int failures;

  logic [8:0] src_mem [N][DEPTH];
  int         src_wr  [N];
  int         src_rd  [N];
  logic [N-1:0] acc;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_last   (req_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int r, input int len, input logic [7:0] base, input bit has_last);
    for (int j = 0; j < len; j++) begin
      src_mem[r][src_wr[r]] = {has_last && (j == len - 1), base + 8'(j)};
      src_wr[r]++;
    end
  endtask

  task automatic expect_bytes(input logic [7:0] base, input int len);
    for (int j = 0; j < len; j++) exp_q.push_back(base + 8'(j));
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
  endtask

  task automatic wait_dv(input string name);
    int n = 0;
    while (down_valid !== 1'b1 && n < 20) begin tick(1); n++; end
    check(name, down_valid, 1);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (req_ready === '0 && n < 20) begin tick(1); n++; end
    check(name, (req_ready !== '0), 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(1); n++; end
    check(name, exp_q.size(), 0);
    tick(2);
  endtask

  // Byte sources: present head of each queue, advance on the acceptance seen before the edge.
  always @(negedge clk) acc = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) src_rd[i]++;
      if (src_rd[i] < src_wr[i]) begin
        {req_last[i], req_data[i]} = src_mem[i][src_rd[i]];
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i]  = 8'h00;
      end
    end
  end

  // Monitor: every byte leaving toward the transmitter must match the scoreboard head.
  always @(negedge clk) begin
    if (arstn && down_valid && down_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra: got %02h, required no byte (t=%0t)", down_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("stream_byte", down_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_to;
    checks     = 0;
    failures   = 0;
    arstn      = 1'b0;
    down_ready = 1'b1;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    acc        = '0;
    for (int i = 0; i < N; i++) begin src_wr[i] = 0; src_rd[i] = 0; end

    // Reset with all four requesters pending, then fairness across 2-byte frames.
    push_frame(0, 2, 8'hA0, 1'b1);
    push_frame(1, 2, 8'hB0, 1'b1);
    push_frame(2, 2, 8'hC0, 1'b1);
    push_frame(3, 2, 8'hD0, 1'b1);
    expect_bytes(8'hA0, 2);
    expect_bytes(8'hB0, 2);
    expect_bytes(8'hC0, 2);
    expect_bytes(8'hD0, 2);
    tick(2);
    check("rst_req_valid_seen", req_valid, 4'b1111);
    check("rst_req_ready",  req_ready,  0);
    check("rst_down_valid", down_valid, 0);
    check("rst_down_data",  down_data,  0);
    check("rst_grant_id",   grant_id,   0);
    check("rst_busy",       busy,       0);
    check("rst_timeout",    timeout,    0);
    arstn = 1'b1;
    tick(1);
    check("fair_first_grant", grant_id, 0);
    check("fair_ready0",      req_ready, 4'b0001);
    check("fair_busy",        busy,      1);
    tick(1);
    check("fair_dv_a0",   down_valid, 1);
    check("fair_data_a0", down_data,  8'hA0);
    tick(1);
    check("fair_data_a1",    down_data, 8'hA1);
    check("fair_idle_ready", req_ready, 0);
    tick(1);
    check("fair_dead_cycle", down_valid, 0);
    check("fair_grant_b",    grant_id,   1);
    check("fair_ready1",     req_ready,  4'b0010);
    wait_drain("fair_drain");

    // Backpressure: 20 stalled cycles after the first byte of a 4-byte frame.
    push_frame(2, 4, 8'h20, 1'b1);
    expect_bytes(8'h20, 4);
    wait_dv("bp_first_byte");
    check("bp_data_first", down_data, 8'h20);
    down_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("bp_data_hold",  down_data,  8'h20);
      check("bp_valid_hold", down_valid, 1);
      check("bp_ready_low",  req_ready,  0);
    end
    down_ready = 1'b1;
    wait_drain("bp_drain");

    // Single-byte frame from requester 3 leaves rr_ptr at 3.
    push_frame(3, 1, 8'h3F, 1'b1);
    expect_bytes(8'h3F, 1);
    wait_grant("single_grant");
    check("single_ready3", req_ready, 4'b1000);
    check("single_id",     grant_id,  3);
    tick(1);
    check("single_one_cycle", req_ready,  0);
    check("single_data",      down_data,  8'h3F);
    check("single_busy_dv",   busy,       1);
    tick(1);
    check("single_busy_clear", busy, 0);
    wait_drain("single_drain");

    // Wrap-around: 1 and 3 pending with rr_ptr=3 -> 1 first, then 3.
    push_frame(1, 2, 8'h11, 1'b1);
    push_frame(3, 2, 8'h33, 1'b1);
    expect_bytes(8'h11, 2);
    expect_bytes(8'h33, 2);
    wait_grant("wrap_grant");
    check("wrap_first", req_ready, 4'b0010);
    wait_drain("wrap_drain");

    // Mid-frame reset: rr_ptr=0 beforehand, so only reset priority grants 0 before 1.
    push_frame(0, 1, 8'h50, 1'b1);
    expect_bytes(8'h50, 1);
    wait_drain("pre_reset_drain");
    push_frame(2, 4, 8'h60, 1'b1);
    expect_bytes(8'h60, 1);
    wait_dv("mr_first_byte");
    check("mr_data_b1", down_data, 8'h60);
    tick(1);
    check("mr_data_b2",  down_data,    8'h61);
    check("mr_consumed", exp_q.size(), 0);
    arstn = 1'b0;
    flush_sources();
    #1;
    check("mr_down_valid", down_valid, 0);
    check("mr_req_ready",  req_ready,  0);
    check("mr_busy",       busy,       0);
    check("mr_grant_id",   grant_id,   0);
    tick(1);
    arstn = 1'b1;
    push_frame(0, 1, 8'h70, 1'b1);
    push_frame(1, 1, 8'h71, 1'b1);
    expect_bytes(8'h70, 1);
    expect_bytes(8'h71, 1);
    wait_grant("mr_grant");
    check("mr_reset_priority", req_ready, 4'b0001);
    wait_drain("mr_drain");

    // Stalled grantee: requester 2 sends one non-last byte, requester 3 waits.
    push_frame(2, 1, 8'h80, 1'b0);
    push_frame(3, 1, 8'h90, 1'b1);
    expect_bytes(8'h80, 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    expect_bytes(8'h90, 1);
`endif
    wait_dv("to_first_byte");
    check("to_data", down_data, 8'h80);
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n = 0;
      while (timeout !== 1'b1 && n < 40) begin tick(1); n++; end
      check("to_latency", n, 16);
    end
    tick(1);
    check("to_pulse_end", timeout,   0);
    check("to_next_ready", req_ready, 4'b1000);
    check("to_next_id",    grant_id,  3);
    wait_drain("to_drain");
`else
    seen_to = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      seen_to |= timeout;
    end
    check("stall_no_timeout", seen_to,   0);
    check("stall_busy",       busy,      1);
    check("stall_grant_id",   grant_id,  2);
    check("stall_ready",      req_ready, 4'b0100);
    check("stall_drained",    exp_q.size(), 0);
    arstn = 1'b0;
    flush_sources();
    tick(1);
    arstn = 1'b1;
    tick(2);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
